// File: rtl/gf_mul_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial GF(2^m) multiplier.
package gf_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reduction tail for B-163: x^163 + x^7 + x^6 + x^3 + 1
  localparam logic [162:0] G_B163 = 163'hC9;

  function automatic int num_digits(input int dataWidth, input int digitBits);
    return (dataWidth + digitBits - 1) / digitBits;
  endfunction

  // Bits needed to count 0..n-1, never less than one
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gf_digit_step.sv
// Combinational multiply step: folds one DIGITAL-bit digit of b into the accumulator,
// MSB of the digit first, reducing by f(x) = x^m + g after every bit.
module gf_digit_step #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 64
) (
  input  logic [DIGITAL-1:0]    digit,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] g,
  input  logic [DATA_WIDTH-1:0] t_in,
  output logic [DATA_WIDTH-1:0] t_out
);

  logic [DATA_WIDTH-1:0] acc;

  // Horner chain: t <- t*x mod f, then add a when the digit bit is set
  always_comb begin
    acc = t_in;
    for (int i = DIGITAL - 1; i >= 0; i--) begin
      acc = {acc[DATA_WIDTH-2:0], 1'b0}
            ^ (acc[DATA_WIDTH-1] ? g : '0)
            ^ (digit[i] ? a : '0);
    end
    t_out = acc;
  end

endmodule

// File: rtl/gf_mul_digit_ctrl.sv
// Sequential front end for the digit-serial GF(2^m) multiplier: latches operands,
// feeds b one digit per clock into gf_digit_step and returns a*b mod f.
module gf_mul_digit_ctrl
  import gf_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] g,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGITAL);
  localparam int CNT_W      = clog2_min1(NUM_DIGITS);
  localparam int PAD_W      = NUM_DIGITS * DIGITAL;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] g_q, g_d;
  logic [DATA_WIDTH-1:0] t_q, t_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [PAD_W-1:0]      bsh_q, bsh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIGITAL-1:0]    digit;
  logic [DATA_WIDTH-1:0] stepOut;

  assign digit = bsh_q[PAD_W-1 -: DIGITAL];

  gf_digit_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIGITAL   (DIGITAL)
  ) u_step (
    .digit(digit),
    .a    (a_q),
    .g    (g_q),
    .t_in (t_q),
    .t_out(stepOut)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
  end

  // Datapath next state; operands are only sampled on the accepting IDLE edge
  always_comb begin
    a_d      = a_q;
    g_d      = g_q;
    t_d      = t_q;
    bsh_d    = bsh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          g_d   = g;
          bsh_d = PAD_W'(b);
          t_d   = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        t_d   = stepOut;
        bsh_d = bsh_q << DIGITAL;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) result_d = stepOut;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      g_q      <= '0;
      t_q      <= '0;
      bsh_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      g_q      <= g_d;
      t_q      <= t_d;
      bsh_q    <= bsh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/gf_mul_digit_ctrl.md
Name: gf_mul_digit_ctrl

Overview:
Sequential front end for the combinational digit-serial GF(2^m) multiply step.
- Accepts operands a, b and reduction tail g over a valid/ready handshake.
- Feeds b to the step logic one DIGITAL-bit digit per clock, most significant digit first, and holds the accumulator t in a register.
- Returns a*b mod f(x) over a valid/ready handshake.
- Sits between the SoC bus adapter and the step datapath; it is the block that drives that datapath's digit and accumulator inputs.

Parameters:
- DATA_WIDTH, 163, field degree m; width of a, b, g, result.
- DIGITAL, 64, digit size in bits of b consumed per clock; 1 <= DIGITAL <= DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  DATA_WIDTH  multiplicand; caller guarantees it is reduced.
- b  input  DATA_WIDTH  multiplier; caller guarantees it is reduced.
- g  input  DATA_WIDTH  f(x) minus x^m. For B-163 (x^163+x^7+x^6+x^3+1), g = 0xC9.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  DATA_WIDTH  a*b mod f.

Behaviour:
Clock and reset:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, result=0, state=IDLE, digit count=0, accumulator t=0.

Constants:
- NUM_DIGITS = ceil(DATA_WIDTH/DIGITAL); 3 at the defaults.
- b is zero-extended at the MSB end to NUM_DIGITS*DIGITAL bits.
- Leading zero padding is harmless because t stays 0 until the first 1 bit of b.

Step function (per bit of a digit, MSB of the digit first):
- t' = {t[m-2:0],0} XOR (t[m-1] ? g : 0) XOR (bit ? a : 0).
- One digit applies this DIGITAL times, combinationally, within one clock.

State machine:
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, g, and padded b into the shift register; t<=0; count<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each clock: t<=step(t, top digit); shift the b register left by DIGITAL; count<=count+1.
  - When count==NUM_DIGITS-1: result<=the step output (the final t); go to DONE.
- DONE:
  - out_valid=1; result is held stable.
  - On out_ready: out_valid<=0; go to IDLE.

Latency and throughput:
- out_valid rises exactly NUM_DIGITS clocks after the acceptance edge (3 at defaults).
- Throughput is one operation per NUM_DIGITS+2 clocks minimum.

Boundary conditions:
- in_valid asserted in RUN or DONE is ignored; operands are not latched and there is no side effect.
- Operand inputs may change after acceptance without affecting the running operation.
- out_ready asserted outside DONE has no effect.
- rst in any state, including mid-RUN, returns to the reset values on the next edge; the partial result is discarded.
- DIGITAL == DATA_WIDTH gives NUM_DIGITS=1: RUN lasts one clock.
- count width is clog2(NUM_DIGITS), minimum 1 bit.

Decomposition:
- Shared package gf_mul_pkg holds:
  - state enum IDLE/RUN/DONE;
  - function num_digits(DATA_WIDTH, DIGITAL);
  - constant G_B163 = 163'hC9;
  - clog2 helper.
- One sub-module, gf_digit_step:
  - combinational; inputs digit, a, g, t_in; output t_out;
  - a chain of DIGITAL single-bit steps, MSB of the digit first.
- Everything sequential stays in gf_mul_digit_ctrl.

Test Plan:
- a=1, b=0x5A5A_1234, g=0xC9 -> out_valid exactly 3 clocks after the accept edge; result=0x5A5A_1234.
- a=2 (x), b=1<<162, g=0xC9 -> result=0xC9 (x^163 reduced).
- a=0, b=all-ones(163) -> result=0. Also swap operands, with random a, b checked against a software model, 1000 vectors; results must commute.
- Backpressure: out_ready low for 5 clocks after out_valid -> result stable and out_valid held; in_valid pulsed during RUN and DONE -> ignored, and the next accepted op is correct.
- Reset at the 2nd RUN clock -> next edge shows in_ready=1, out_valid=0, result=0; a following op (a=3, b=3) -> result=5.
- Rebuild with DIGITAL=1 and DIGITAL=163 -> the same vectors match; out_valid latency is 163 and 1 clocks respectively.
